// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the round-robin output-mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int NREQ_DEF     = 4;
  localparam int DW_DEF       = 7;
  localparam int MAX_HOLD_DEF = 4;

  // Beat counter width; holds MAX_HOLD up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set req bit at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int SW = $clog2(NREQ);

  int j;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        any = 1'b1;
        idx = SW'(j);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that grants one requester at a time the shared output
// mux for a burst, releasing on last beat, hold limit, or dropped request.
//
//   state | meaning
//   IDLE  | no owner; pick next winner when en=1 and any req is set
//   XFER  | owner drives the output; beats counted until release
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         gnt,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  input  logic                    out_ready,
  output logic [$clog2(NREQ)-1:0] out_sel,
  output logic                    busy
);

  localparam int SW = $clog2(NREQ);

  state_t         state, state_nxt;
  logic [SW-1:0]  owner, owner_nxt;
  logic [SW-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic           pick_any;
  logic [SW-1:0]  pick_idx;
  logic           own_req;
  logic           own_last;
  logic           cnt_hit;
  logic           rel;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign own_req  = req[owner];
  assign own_last = req_last[owner];
  // True when the beat happening now would reach the hold limit.
  assign cnt_hit  = (cnt + 1'b1) == CNT_W'(MAX_HOLD);

  // Next-state: grant from IDLE, count beats and decide release in XFER.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        if (en && pick_any) begin
          owner_nxt = pick_idx;
          cnt_nxt   = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (!own_req) begin
          rel = 1'b1;
        end else if (out_ready) begin
          cnt_nxt = cnt + 1'b1;
          rel     = own_last || cnt_hit;
        end
        if (rel) begin
          state_nxt = IDLE;
          ptr_nxt   = (owner == SW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output mux: owner's data/valid in XFER, everything quiet otherwise.
  always_comb begin
    busy      = (state == XFER);
    out_sel   = owner;
    out_valid = 1'b0;
    out_data  = '0;
    gnt       = '0;
    if (state == XFER) begin
      out_valid  = own_req;
      out_data   = req_data[int'(owner)*DW +: DW];
      gnt[owner] = out_ready;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a behavioural reference model.
module tb_mux_rr_arbiter;

  localparam int NREQ     = 4;
  localparam int DW       = 7;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  logic [1:0]        out_sel;
  logic              busy;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: whether a burst is running, who owns it, where
  // the search starts next, and beats taken so far.
  int m_busy, m_owner, m_ptr, m_cnt;

  logic [NREQ-1:0] obs_gnt;
  logic            obs_valid, obs_busy, prev_busy;
  logic [DW-1:0]   obs_data;
  logic [1:0]      obs_sel;
  int grant_log[$];
  int beat_log[$];
  int beats_cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < NREQ; k++) begin
      if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    int rel;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_busy == 0) begin
      w = winner();
      if (en && w >= 0) begin
        m_owner = w; m_cnt = 0; m_busy = 1;
      end
    end else begin
      rel = 0;
      if (!req[m_owner]) rel = 1;
      else if (out_ready) begin
        m_cnt++;
        if (req_last[m_owner] || m_cnt == MAX_HOLD) rel = 1;
      end
      if (rel != 0) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end
  endtask

  // One clock cycle: fresh data, compare outputs with the model, advance.
  task automatic tick();
    logic [NREQ-1:0] e_gnt;
    logic [DW-1:0]   e_data;
    logic            e_valid;
    req_data = (NREQ*DW)'($urandom);
    #1;
    e_gnt   = '0;
    e_data  = '0;
    e_valid = 1'b0;
    if (m_busy != 0) begin
      e_valid = req[m_owner];
      e_data  = req_data[m_owner*DW +: DW];
      if (out_ready) e_gnt[m_owner] = 1'b1;
    end
    check("gnt",       32'(gnt),       32'(e_gnt));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out_data",  32'(out_data),  32'(e_data));
    check("out_sel",   32'(out_sel),   32'(m_owner));
    check("busy",      32'(busy),      32'(m_busy));
    obs_gnt = gnt; obs_valid = out_valid; obs_busy = busy;
    obs_data = out_data; obs_sel = out_sel;
    if (obs_busy && !prev_busy) begin
      grant_log.push_back(int'(obs_sel));
      beats_cur = 0;
    end
    if (obs_busy && obs_valid && obs_gnt != '0) beats_cur++;
    if (!obs_busy && prev_busy) beat_log.push_back(beats_cur);
    prev_busy = obs_busy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = '0; req_last = '0; out_ready = 1'b1;
    req_data = '0; prev_busy = 1'b0; beats_cur = 0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single requester, two-beat burst, then ptr has moved to 1.
    do_reset();
    req = 4'b0001; out_ready = 1'b1;
    tick();
    tick();
    check("r22_gnt_c1", 32'(obs_gnt), 32'h1);
    req_last = 4'b0001;
    tick();
    check("r22_gnt_c2", 32'(obs_gnt), 32'h1);
    req_last = '0; req = 4'b0011;
    tick();
    check("r22_idle_c3", 32'(obs_busy), 32'h0);
    tick();
    check("r22_ptr1", 32'(obs_sel), 32'h1);
    req = '0;
    tick();
    tick();

    // All requesting, hold limit forces rotation 0,1,2,3,0.
    do_reset();
    grant_log.delete(); beat_log.delete();
    req = 4'b1111; req_last = '0; out_ready = 1'b1;
    for (int i = 0; i < 27; i++) tick();
    check("r23_ngrants", 32'(grant_log.size() >= 5), 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("r23_owner", 32'((i < grant_log.size()) ? grant_log[i] : -1), 32'(i % NREQ));
      check("r23_beats", 32'((i < beat_log.size()) ? beat_log[i] : -1), 32'(MAX_HOLD));
    end
    req = '0;
    tick();
    tick();

    // Stall with out_ready low: owner kept, data follows requester 2.
    do_reset();
    req = 4'b0100; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("r24_stall_busy", 32'(obs_busy), 32'h1);
      check("r24_stall_data", 32'(obs_data), 32'(req_data[2*DW +: DW]));
    end
    out_ready = 1'b1;
    tick();
    check("r24_first_beat", 32'(obs_gnt), 32'h4);
    req = '0;
    tick();
    tick();

    // Pointer at 3 wraps to 0 after owner 3 releases.
    do_reset();
    req = 4'b0100; req_last = 4'b0100; out_ready = 1'b1;
    tick();
    tick();
    req = 4'b1001; req_last = '0;
    tick();
    req_last = 4'b1000;
    tick();
    check("r25_owner3", 32'(obs_sel), 32'h3);
    req_last = '0;
    tick();
    tick();
    check("r25_owner0", 32'(obs_sel), 32'h0);
    req = '0;
    tick();
    tick();

    // en dropped mid-burst: burst completes, then no new grant.
    do_reset();
    req = 4'b0010; en = 1'b1; out_ready = 1'b1;
    tick();
    en = 1'b0; req = 4'b1111;
    tick();
    tick();
    req_last = 4'b0010;
    tick();
    check("r26_completes", 32'(obs_gnt), 32'h2);
    req_last = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r26_held_idle", 32'(obs_busy), 32'h0);
    end
    en = 1'b1; req = '0;
    tick();

    // Reset during third beat of owner 2, then fresh grant from count 0.
    do_reset();
    req = 4'b0100; out_ready = 1'b1; req_last = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("r27_gnt0",   32'(obs_gnt),   32'h0);
    check("r27_valid0", 32'(obs_valid), 32'h0);
    check("r27_sel0",   32'(obs_sel),   32'h0);
    for (int i = 0; i < 6; i++) tick();
    req = '0;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      en        = ($urandom_range(0, 7) != 0);
      req       = NREQ'($urandom);
      req_last  = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
